// File: rtl/svo_tmds_dec.sv
// TMDS receive decoder for one channel: control-token word alignment with bitslip, 2-cycle din->out latency, no backpressure.
// Defining TMDS_DEC_STATS_EN adds saturating slip_count / lock_loss_count outputs.
module svo_tmds_dec #(
  parameter int LOCK_TOKENS = 16,
  parameter int TIMEOUT     = 4095,
  parameter int SLIP_WAIT   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [7:0] slip_count,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam logic [TOK_W-1:0]  TOK_MAX   = TOK_W'(LOCK_TOKENS);
  localparam logic [11:0]       TMR_MAX   = 12'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [TOK_W-1:0]  tok_cnt, tok_cnt_nxt, tok_inc;
  logic [11:0]       tmr, tmr_nxt, tmr_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic       tok_in;
  logic [1:0] code_in;
  logic [9:0] s1_dat;
  logic       s1_tok;
  logic [1:0] s1_code;
  logic [7:0] q, dec;

  always_comb begin
    tok_in  = 1'b1;
    code_in = 2'b00;
    case (din)
      10'b1101010100: code_in = 2'b00;
      10'b0010101011: code_in = 2'b01;
      10'b0101010100: code_in = 2'b10;
      10'b1010101011: code_in = 2'b11;
      default:        tok_in  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the xor/xnor transition chain.
  always_comb begin
    q      = s1_dat[9] ? ~s1_dat[7:0] : s1_dat[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = s1_dat[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_dat  <= '0;
      s1_tok  <= 1'b0;
      s1_code <= 2'b00;
      de      <= 1'b0;
      ctrl    <= 2'b00;
      dout    <= '0;
    end else begin
      s1_dat  <= din;
      s1_tok  <= tok_in;
      s1_code <= code_in;
      if (!locked) begin
        de   <= 1'b0;
        ctrl <= 2'b00;
        dout <= '0;
      end else if (s1_tok) begin
        de   <= 1'b0;
        ctrl <= s1_code;
        dout <= '0;
      end else begin
        de   <= 1'b1;
        dout <= dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= SEARCH;
      tok_cnt  <= '0;
      tmr      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tok_cnt  <= tok_cnt_nxt;
      tmr      <= tmr_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    tok_inc      = (tok_cnt == TOK_MAX) ? TOK_MAX : tok_cnt + TOK_W'(1);
    tmr_inc      = (tmr == TMR_MAX) ? TMR_MAX : tmr + 12'd1;
    state_nxt    = state;
    tok_cnt_nxt  = tok_cnt;
    tmr_nxt      = tmr;
    wait_cnt_nxt = wait_cnt;
    bitslip      = 1'b0;
    locked       = 1'b0;
    case (state)
      SEARCH: begin
        tok_cnt_nxt = tok_in ? tok_inc : '0;
        tmr_nxt     = tmr_inc;
        // Lock is checked first so it wins over a coincident timeout.
        if (tok_in && tok_inc == TOK_MAX) begin
          state_nxt   = LOCKED;
          tok_cnt_nxt = '0;
          tmr_nxt     = '0;
        end else if (tmr_inc == TMR_MAX) begin
          state_nxt = SLIP;
        end
      end
      SLIP: begin
        bitslip      = 1'b1;
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_LAST) begin
          state_nxt   = SEARCH;
          tok_cnt_nxt = '0;
          tmr_nxt     = '0;
        end
      end
      LOCKED: begin
        locked  = 1'b1;
        tmr_nxt = tok_in ? '0 : tmr_inc;
        if (!tok_in && tmr_inc == TMR_MAX) begin
          state_nxt   = SEARCH;
          tok_cnt_nxt = '0;
          tmr_nxt     = '0;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slip_count      <= '0;
      lock_loss_count <= '0;
    end else begin
      if (state == SLIP && slip_count != 8'hFF) begin
        slip_count <= slip_count + 8'd1;
      end
      if (state == LOCKED && state_nxt == SEARCH && lock_loss_count != 8'hFF) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/svo_tmds_dec.md
Name: svo_tmds_dec

Overview:
- Receive-side TMDS decoder for one DVI/HDMI channel; the inverse of the team's TMDS encoder.
- Takes 10-bit parallel words from the deserializer, in the pixel clock domain.
- Finds word alignment by searching for control-token runs during blanking; drives a one-cycle bitslip request to the deserializer.
- Once locked, outputs 8-bit video data, `de` and 2-bit control.

Parameters:
- LOCK_TOKENS, 16: consecutive control tokens required to declare lock.
- TIMEOUT, 4095: cycles without lock (search) or without any control token (locked) before acting; counter width is 12 bits.
- SLIP_WAIT, 8: settle cycles after a bitslip pulse before searching again.

Ports:
- clk  in  1  pixel clock
- resetn  in  1  synchronous active-low reset
- din  in  10  raw TMDS word from the deserializer, bit 0 transmitted first
- bitslip  out  1  one-cycle pulse; deserializer shifts alignment by one bit
- locked  out  1  alignment achieved
- de  out  1  data enable, decoded
- ctrl  out  2  control bits {C1,C0}, valid when de=0
- dout  out  8  decoded video byte, valid when de=1

Interface: one clock; reset is synchronous and active-low (clk, resetn).

Behaviour:
- Control tokens (exact match on din):
  - 10'b1101010100 = 00
  - 10'b0010101011 = 01
  - 10'b0101010100 = 10
  - 10'b1010101011 = 11
- Any other word is a data word.
- Reset values: bitslip=0, locked=0, de=0, ctrl=0, dout=0. The FSM enters SEARCH and all counters clear. Reset asserted mid-operation acts in the same cycle and drops lock immediately.
- Pipeline:
  - Stage 1 registers din and an is_token flag.
  - Stage 2 registers de/ctrl/dout.
  - Fixed latency: a word on din at edge N appears on the outputs after edge N+2.
- Decode, stage 2:
  - Token: de=0, ctrl=token code, dout=0.
  - Data word:
    - de=1; ctrl holds its previous value.
    - q = din[9] ? ~din[7:0] : din[7:0].
    - dout[0] = q[0].
    - For i=1..7: dout[i] = din[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Output gating: while locked=0 (sampled at stage 2), de=0, ctrl=0 and dout=0 regardless of din.
- FSM states: SEARCH, SLIP, WAIT, LOCKED.
  - SEARCH:
    - tok_cnt increments on each token and clears on each data word.
    - tmr increments every cycle.
    - tok_cnt reaching LOCK_TOKENS goes to LOCKED: locked=1 next cycle, tmr clears.
    - Otherwise, tmr reaching TIMEOUT goes to SLIP.
  - SLIP: bitslip=1 for exactly one cycle, then go to WAIT.
  - WAIT:
    - Count SLIP_WAIT cycles; din is ignored.
    - Then go to SEARCH with tok_cnt=0 and tmr=0.
  - LOCKED:
    - tmr clears on any token and increments otherwise.
    - tmr reaching TIMEOUT goes to SEARCH: locked=0, no bitslip.
- Simultaneous events: if, in SEARCH, the token that makes tok_cnt reach LOCK_TOKENS arrives in the same cycle tmr reaches TIMEOUT, lock wins.
- Arithmetic: tok_cnt saturates at LOCK_TOKENS and tmr saturates at TIMEOUT; neither wraps.
- Unbounded slipping: slips repeat until lock. No slip limit; the deserializer wraps its own alignment modulo 10.

Optional Feature:
- Macro: TMDS_DEC_STATS_EN.
- When defined, adds output `slip_count` [7:0] and output `lock_loss_count` [7:0].
  - slip_count increments on every bitslip pulse.
  - lock_loss_count increments on every LOCKED to SEARCH transition.
  - Both counters saturate at 255 and clear only on reset.
- When undefined, neither port nor logic exists, and all other behaviour is identical.

Test Plan (LOCK_TOKENS=4, TIMEOUT=64, SLIP_WAIT=8 unless stated):
- Aligned lock:
  - Stimulus: reset, then 4× 10'b1101010100.
  - Response: locked=1 one cycle after the 4th token. No bitslip ever pulses. The next token yields de=0, ctrl=00 two cycles after its input.
- Data decode, after lock:
  - Stimulus: din=10'b0100000000, then 10'b1000000000, then 10'b1010101011.
  - Response, each two cycles after its input: de=1/dout=8'h00, then de=1/dout=8'hFF, then de=0/ctrl=11.
- Misalignment recovery:
  - Stimulus: a bench deserializer model rotating the stream by 3 bits, with blanking-heavy traffic.
  - Response: bitslip pulses one cycle wide, each at least 1+SLIP_WAIT cycles apart; locked=1 after the 7th slip; decoded data then matches the transmitted data.
- Lock loss:
  - Stimulus: while locked, 64 consecutive data words.
  - Response: locked=0 after the 64th. Outputs are gated to de=0/dout=0 two cycles later. No bitslip until a further 64 cycles pass without reaching lock.
- Reset mid-operation:
  - Stimulus: assert resetn=0 for 1 cycle while locked and de=1.
  - Response: next cycle locked=0, de=0, dout=0, ctrl=0. Relock needs 4 fresh tokens.
- Stats (TMDS_DEC_STATS_EN):
  - Stimulus: run the misalignment scenario, then the lock-loss scenario.
  - Response: slip_count=7, lock_loss_count=1; both saturate at 255 under a forced 300-slip run.
